// File: rtl/jtkcpu_shseq_pkg.sv
// jtkcpu_shseq_pkg: shift opcodes, CC bit indices, sequencer states and shift classes
package jtkcpu_shseq_pkg;
  localparam logic [7:0] LSRD_IMM = 8'hB0, LSRD_IDX = 8'hB1, ASRD_IMM = 8'hB2, ASRD_IDX = 8'hB3,
    ASLD_IMM = 8'hB4, ASLD_IDX = 8'hB5, RORD_IMM = 8'hB6, RORD_IDX = 8'hB7, ROLD_IMM = 8'hB8,
    ROLD_IDX = 8'hB9, LSRW = 8'hBA, ASRW = 8'hBB, ASLW = 8'hBC, RORW = 8'hBD, ROLW = 8'hBE;
  localparam int CC_C = 0, CC_V = 1, CC_Z = 2, CC_N = 3, CC_I = 4, CC_H = 5, CC_F = 6, CC_E = 7;
  localparam int ROT_PERIOD = 17;
  typedef enum logic [1:0] { S_IDLE, S_RUN, S_DONE } state_t;
  typedef enum logic [1:0] { SH_LOG, SH_ARI, SH_ROT } shcls_t;
endpackage

// File: rtl/jtkcpu_shseq_shcnt.sv
// jtkcpu_shcnt: shift class decode; JTKCPU_SHSEQ_FAST_EN reduces the count to its shortest equivalent
module jtkcpu_shcnt import jtkcpu_shseq_pkg::*; #(
  parameter int CW = 8
) (
  input  logic [7:0]    op,
  input  logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_o
);
  shcls_t cls;
  assign cls = op inside {RORD_IMM, RORD_IDX, RORW, ROLD_IMM, ROLD_IDX, ROLW} ? SH_ROT
             : op inside {ASRD_IMM, ASRD_IDX, ASRW} ? SH_ARI : SH_LOG;
`ifdef JTKCPU_SHSEQ_FAST_EN
  assign cnt_o = cls == SH_ROT ? (cnt == '0 ? '0 : CW'((32'(cnt) - 1) % ROT_PERIOD + 1))
                               : (32'(cnt) > ROT_PERIOD ? CW'(ROT_PERIOD) : cnt);
`else
  logic unused_cls;
  assign unused_cls = ^{cls};
  assign cnt_o = cnt;
`endif
endmodule

// File: rtl/jtkcpu_shseq.sv
// jtkcpu_shseq: shift-by-count sequencer feeding a one-bit ALU back on itself; JTKCPU_SHSEQ_FAST_EN shortens counts
module jtkcpu_shseq import jtkcpu_shseq_pkg::*; #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic [7:0]    op,
  input  logic [CW-1:0] cnt,
  input  logic [15:0]   val,
  input  logic [7:0]    cc_in,
  output logic [7:0]    alu_op,
  output logic [15:0]   alu_opnd0,
  output logic [7:0]    alu_cc,
  input  logic [15:0]   alu_rslt,
  input  logic [7:0]    alu_cc_out,
  output logic          busy,
  output logic          done,
  output logic [15:0]   rslt,
  output logic [7:0]    cc_out
);
  state_t        state_q, state_d;
  logic [15:0]   acc_q, acc_d, rslt_q, rslt_d;
  logic [7:0]    op_q, op_d, ccr_q, ccr_d, cc_out_q, cc_out_d;
  logic [CW-1:0] rem_q, rem_d, cnt_r;
  logic          go, zero, run, last;
  jtkcpu_shcnt #(.CW(CW)) u_shcnt (.op(op), .cnt(cnt), .cnt_o(cnt_r));
  assign go   = state_q == S_IDLE && start;
  assign zero = cnt_r == '0;
  assign run  = state_q == S_RUN;
  assign last = run && rem_q == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else if (cen) state_q <= state_d;
  always_comb
    state_d = go ? (zero ? S_DONE : S_RUN) : last ? S_DONE : state_q == S_DONE ? S_IDLE : state_q;
  always_comb begin
    op_d     = go ? op : op_q;
    acc_d    = go ? val : run ? alu_rslt : acc_q;
    ccr_d    = go ? cc_in : run ? alu_cc_out : ccr_q;
    rem_d    = go ? cnt_r : run ? rem_q - CW'(1) : rem_q;
    rslt_d   = go && zero ? val : last ? alu_rslt : rslt_q;
    cc_out_d = go && zero ? cc_in : last ? alu_cc_out : cc_out_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q     <= '0;
      acc_q    <= '0;
      ccr_q    <= '0;
      rem_q    <= '0;
      rslt_q   <= '0;
      cc_out_q <= '0;
    end else if (cen) begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      ccr_q    <= ccr_d;
      rem_q    <= rem_d;
      rslt_q   <= rslt_d;
      cc_out_q <= cc_out_d;
    end
  always_comb begin
    busy      = state_q == S_RUN;
    done      = state_q == S_DONE;
    alu_op    = op_q;
    alu_opnd0 = acc_q;
    alu_cc    = ccr_q;
    rslt      = rslt_q;
    cc_out    = cc_out_q;
  end
endmodule

// File: tb/tb_jtkcpu_shseq.sv
// tb_jtkcpu_shseq: random and directed shift sequences scored against a closed-form shift/rotate model
module tb_jtkcpu_shseq;
  import jtkcpu_shseq_pkg::*;
  logic clk, rst_n, cen, start;
  logic [7:0] op, cc_in, alu_op, alu_cc, alu_cc_out, cc_out;
  logic [7:0] cnt;
  logic [15:0] val, alu_opnd0, alu_rslt, rslt;
  logic busy, done;
  int checks = 0, errors = 0, ncen = 0, nbusy = 0, ndone = 0, npush = 0, cen_mode = 0;
  logic done_prev = 0;
  logic [23:0] sb[$];
  logic [7:0] op_tab [15] = '{LSRD_IMM, LSRD_IDX, ASRD_IMM, ASRD_IDX, ASLD_IMM, ASLD_IDX, RORD_IMM,
                              RORD_IDX, ROLD_IMM, ROLD_IDX, LSRW, ASRW, ASLW, RORW, ROLW};

  jtkcpu_shseq dut (.clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .op(op), .cnt(cnt),
    .val(val), .cc_in(cc_in), .alu_op(alu_op), .alu_opnd0(alu_opnd0), .alu_cc(alu_cc),
    .alu_rslt(alu_rslt), .alu_cc_out(alu_cc_out), .busy(busy), .done(done), .rslt(rslt), .cc_out(cc_out));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) cen <= cen_mode == 0 ? 1'b1 : cen_mode == 1 ? ~cen : 1'($urandom_range(0, 1));
  always @(posedge clk) if (cen) ncen <= ncen + 1;
  always @(posedge clk) if (cen && busy) nbusy <= nbusy + 1;

  // 0 LSR, 1 ASR, 2 ASL, 3 ROR, 4 ROL
  function automatic int kind_of(input logic [7:0] o);
    case (o)
      ASRD_IMM, ASRD_IDX, ASRW: return 1;
      ASLD_IMM, ASLD_IDX, ASLW: return 2;
      RORD_IMM, RORD_IDX, RORW: return 3;
      ROLD_IMM, ROLD_IDX, ROLW: return 4;
      default: return 0;
    endcase
  endfunction

  int ak;
  logic [15:0] aa;
  always_comb begin
    ak = kind_of(alu_op);
    aa = alu_opnd0;
    alu_rslt = ak == 0 ? aa >> 1 : ak == 1 ? {aa[15], aa[15:1]} : ak == 2 ? aa << 1
             : ak == 3 ? {alu_cc[CC_C], aa[15:1]} : {aa[14:0], alu_cc[CC_C]};
    alu_cc_out = alu_cc;
    alu_cc_out[CC_C] = (ak == 2 || ak == 4) ? aa[15] : aa[0];
    if (ak == 2 || ak == 4) alu_cc_out[CC_V] = aa[15] ^ aa[14];
    alu_cc_out[CC_N] = alu_rslt[15];
    alu_cc_out[CC_Z] = alu_rslt == '0;
  end

  function automatic logic [16:0] rot17(input logic [16:0] x, input bit left, input int s);
    return left ? (x << s) | (x >> (17 - s)) : (x >> s) | (x << (17 - s));
  endfunction

  function automatic logic [23:0] model(input logic [7:0] o, input int n, input logic [15:0] v, input logic [7:0] c);
    logic [15:0] r, p;
    logic [16:0] y, z;
    logic [7:0] f;
    int k;
    if (n == 0) return {v, c};
    k = kind_of(o);
    f = c;
    case (k)
      0: begin r = v >> n; p = v >> (n - 1); f[CC_C] = p[0]; end
      1: begin r = 16'($signed(v) >>> n); p = 16'($signed(v) >>> (n - 1)); f[CC_C] = p[0]; end
      2: begin r = v << n; p = v << (n - 1); f[CC_C] = p[15]; f[CC_V] = p[15] ^ p[14]; end
      default: begin
        y = rot17({c[CC_C], v}, k == 4, n % 17);
        z = rot17({c[CC_C], v}, k == 4, (n - 1) % 17);
        r = y[15:0];
        f[CC_C] = y[16];
        if (k == 4) f[CC_V] = z[15] ^ z[14];
      end
    endcase
    f[CC_N] = r[15];
    f[CC_Z] = r == '0;
    return {r, f};
  endfunction

  function automatic int passes(input logic [7:0] o, input int n);
`ifdef JTKCPU_SHSEQ_FAST_EN
    return kind_of(o) >= 3 ? (n == 0 ? 0 : (n - 1) % 17 + 1) : (n > 17 ? 17 : n);
`else
    return o == o ? n : n;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done && !done_prev) begin
      ndone++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected rslt=%h cc=%h exp=none", rslt, cc_out);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({rslt, cc_out} !== e) begin
          errors++;
          $display("FAIL result act=%h/%h exp=%h/%h", rslt, cc_out, e[23:8], e[7:0]);
        end
      end
    end
    done_prev <= done;
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 600) begin @(negedge clk); t++; end
    if (busy || done) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  task automatic issue(input logic [7:0] o, input int n, input logic [15:0] v, input logic [7:0] c,
                       input logic [23:0] e, input bit mid);
    int p, n0, b0, t;
    p = passes(o, n);
    wait_idle();
    sb.push_back(e);
    npush++;
    n0 = ncen;
    b0 = nbusy;
    op = o; cnt = 8'(n); val = v; cc_in = c; start = 1;
    t = 0;
    while (ncen == n0 && t < 100) begin @(negedge clk); t++; end
    start = 0;
    chk("alu_op_latched", int'(alu_op), int'(o));
    t = 0;
    while (!done && t < 2000) begin
      if (mid && t == 3) begin start = 1; op = ASLD_IMM; cnt = 8'd2; val = ~v; end
      if (mid && t == 5) start = 0;
      @(negedge clk);
      t++;
    end
    chk("done_seen", int'(done), 1);
    chk("latency", ncen - n0, p == 0 ? 1 : p + 1);
    chk("busy_edges", nbusy - b0, p);
  endtask

  task automatic run(input logic [7:0] o, input int n, input logic [15:0] v, input logic [7:0] c, input bit mid);
    issue(o, n, v, c, model(o, n, v, c), mid);
  endtask

  initial begin
    int n0, b0, t;
    logic [15:0] rv;
    rst_n = 0; start = 0; op = 0; cnt = 0; val = 0; cc_in = 0; cen = 1;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rslt", int'(rslt), 0);
    chk("rst_cc_out", int'(cc_out), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_alu_opnd0", int'(alu_opnd0), 0);
    chk("rst_alu_cc", int'(alu_cc), 0);
    @(negedge clk);
    rst_n = 1;
    issue(LSRD_IMM, 3, 16'h8001, 8'h00, {16'h1000, 8'h00}, 0);
    issue(ASLD_IMM, 1, 16'h4000, 8'h00, {16'h8000, 8'h0A}, 0);
    issue(ROLD_IMM, 17, 16'h1234, 8'h00, {16'h1234, 8'h00}, 0);
    issue(ROLD_IMM, 18, 16'h1234, 8'h00, {16'h2468, 8'h00}, 0);
    issue(RORD_IDX, 0, 16'hABCD, 8'h5A, {16'hABCD, 8'h5A}, 0);
    rv = 16'($urandom);
    run(LSRD_IMM, 8, rv, 8'h00, 0);
    cen_mode = 1;
    run(LSRD_IMM, 8, rv, 8'h00, 1);
    for (int i = 0; i < 16; i++) begin
      cen_mode = int'($urandom_range(0, 2));
      run(op_tab[$urandom_range(0, 14)], int'($urandom_range(0, 40)), 16'($urandom), 8'($urandom), 0);
    end
    cen_mode = 2;
    run(ASRD_IDX, 255, 16'h8421, 8'h03, 0);
    cen_mode = 0;
    wait_idle();
    op = LSRD_IMM; cnt = 8'd10; val = 16'hF0F0; cc_in = 8'h00; start = 1;
    n0 = ncen;
    @(negedge clk);
    start = 0;
    b0 = nbusy;
    t = 0;
    while (nbusy - b0 < 4 && t < 50) begin @(negedge clk); t++; end
    chk("mid_run_busy", int'(busy), 1);
    rst_n = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_rslt", int'(rslt), 0);
    chk("arst_cc_out", int'(cc_out), 0);
    chk("arst_alu_opnd0", int'(alu_opnd0), 0);
    @(negedge clk);
    rst_n = 1;
    run(LSRD_IMM, 10, 16'hF0F0, 8'h00, 0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("done_count", ndone, npush);
    chk("scoreboard_empty", sb.size(), 0);
    if (n0 < 0) $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtkcpu_shseq.md
Name: jtkcpu_shseq

Overview:
- Multi-cycle sequencer for the Konami CPU's shift-by-count instructions: LSRD, ASRD, ASLD, RORD and ROLD in their _IMM and _IDX forms, plus the W/8-bit single-shift ops when issued with a count.
- The shared ALU only performs one bit per pass. This block feeds the ALU's result and flags back to its inputs once per enabled cycle until the count is exhausted.
- It sits between the instruction sequencer and the ALU, and drives the ALU's op, opnd0 and cc_in whenever it is busy.

Parameters:
- CW, 8, count width in bits (count comes from the immediate byte or the memory byte).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous and active-low
- cen  in  1  clock enable; all state advances only on clk edges where cen=1
- start  in  1  request a new shift sequence; sampled only when idle and cen=1
- op  in  8  opcode; captured on start and held on alu_op
- cnt  in  CW  shift count
- val  in  16  initial operand
- cc_in  in  8  initial condition codes
- alu_op  out  8  opcode to the ALU
- alu_opnd0  out  16  accumulator to the ALU's opnd0
- alu_cc  out  8  running CC to the ALU's cc_in
- alu_rslt  in  16  ALU result
- alu_cc_out  in  8  ALU flags
- busy  out  1  sequence in progress
- done  out  1  one-cen-cycle completion strobe
- rslt  out  16  final result, valid while done=1 and held until the next start
- cc_out  out  8  final CC, valid while done=1 and held until the next start

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, rst_n=0) values:
  - state=IDLE; busy=0; done=0.
  - rslt=0; cc_out=0; alu_op=0; alu_opnd0=0; alu_cc=0; remaining count=0.
- IDLE, start=1, cen=1 (edge E0):
  - Latch op into alu_op, val into acc, cc_in into ccr, cnt into rem.
  - rem=0: go to DONE; rslt=val; cc_out=cc_in unchanged; busy stays 0.
  - otherwise: go to RUN; busy=1.
- RUN, each cen edge:
  - acc<=alu_rslt; ccr<=alu_cc_out; rem<=rem-1.
  - The ALU is combinational, so exactly one bit is processed per cen edge.
  - When rem==1 at the edge: rslt<=alu_rslt; cc_out<=alu_cc_out; go to DONE; busy<=0.
- DONE: done=1 for exactly one cen cycle, then IDLE at the next cen edge.
- Latency: N>0 gives done high after N+1 cen edges counted from E0. N=0 gives done after edge E0.
- Outputs: alu_opnd0=acc and alu_cc=ccr at all times.
- start while RUN or DONE: ignored, with no queuing.
- cen=0: all state, counters and outputs frozen; done stretches across non-cen cycles.
- Width handling: acc is 16-bit. For 8-bit ops the ALU passes the upper byte through untouched, and the sequencer does not mask it.
- Count is unsigned; 255 is legal and runs 255 passes unless the optional feature below is compiled in.
- rst_n asserted mid-RUN: immediate return to IDLE, done is not emitted, and rslt/cc_out are cleared.

Optional Feature:
- Macro: JTKCPU_SHSEQ_FAST_EN.
- With the macro defined, the count is reduced at E0:
  - LSR/ASR/ASL classes: saturate at 17.
  - ROR/ROL classes: reduce to ((cnt-1) mod 17)+1, since a 16-bit rotate through carry has period 17; cnt=0 stays 0.
  - Results and flags are identical to the full iteration; only latency shrinks.
- Without the macro: exactly cnt passes.

Decomposition:
- Opcode constants come from the shared jtkcpu.inc include, as does the CC bit index naming.
- Add to the include localparams S_IDLE/S_RUN/S_DONE and a shift-class encoding (SH_LOG, SH_ARI, SH_ROT).
- One natural sub-module, jtkcpu_shcnt: op decode to class plus the FAST count reduction (pass-through when FAST_EN is undefined).
- The FSM, accumulator and handshake stay in jtkcpu_shseq.

Test Plan:
- LSRD_IMM, cnt=3, val=16'h8001, cc_in=0 -> done after 4 cen edges; rslt=16'h1000; C=0, N=0, Z=0.
- ASLD_IMM, cnt=1, val=16'h4000 -> rslt=16'h8000; C=0, V=1, N=1; busy high for exactly 1 cen edge.
- ROLD_IMM, cnt=17, val=16'h1234, C=0 -> rslt=16'h1234 and C=0. Requires 17 passes without FAST_EN and 17 with it; cnt=18 with FAST_EN takes 1 pass and gives 16'h2468.
- Any op, cnt=0, val=16'hABCD, cc_in=8'h5A -> done after E0; rslt=16'hABCD; cc_out=8'h5A; busy never asserted.
- LSRD, cnt=8 with cen toggling 1/0 every cycle and start pulsed mid-RUN -> identical result to cen=1 throughout, the second start is ignored, and done is asserted exactly once.
- rst_n pulled low at pass 4 of cnt=10 -> busy=0, done=0, rslt=0 asynchronously; after release a fresh start runs normally.
